lin_interp: RTL and testbench
=============================

Name: lin_interp

Overview:
- Upsampling linear interpolator for 4-bit sample streams; the expanding counterpart of the team's 4-tap moving-average decimating filter.
- Accepts one input sample per handshake and emits R = 2^LOG2R output samples that ramp linearly from the previously accepted sample to the new one.
- Sits between a low-rate sample source and a high-rate consumer, with valid/ready flow control on both sides.

Parameters:
- W, 4, sample width in bits (unsigned).
- LOG2R, 2, log2 of the interpolation ratio; R = 2^LOG2R output beats per input sample.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  input sample present.
- in_ready  output  1  block can accept an input sample.
- in  input  W  input sample.
- out_valid  output  1  output sample present (registered).
- out_ready  input  1  consumer accepts the output sample.
- out  output  W  interpolated output sample (registered).

Behaviour:
- Internal state: prev (W bits, last fully emitted sample), cur (W bits, sample being interpolated), k (LOG2R+1 bits, beat index 1..R), state in {IDLE, RUN}.
- Reset (rst=0, asynchronous): state=IDLE, prev=0, cur=0, k=0, out=0, out_valid=0. Reset mid-RUN aborts the ramp; remaining beats are discarded and no partial sample is retained.
- in_ready = (state==IDLE), decoded from a registered state only, with no combinational path from out_ready. in_ready is 1 while in reset.
- IDLE: on an edge with in_valid & in_ready, cur<=in, k<=1, state<=RUN, out_valid<=1, out<=f(1). The first output is visible in the cycle after the input handshake (latency 1).
- f(k) = prev + floor(((cur - prev) * k) / R):
  - The difference is signed, W+1 bits.
  - The product is signed, W+1+LOG2R bits.
  - Division is an arithmetic right shift by LOG2R, which floors toward minus infinity.
  - The result always lies between prev and cur inclusive, so truncation to W bits is lossless. No saturation logic is needed.
- RUN: out and out_valid hold steady while out_ready=0. This is a stall, with no value changes.
- RUN, on an out handshake with k<R: k<=k+1, out<=f(k+1), and out_valid stays 1.
- RUN, on an out handshake with k==R: out carried cur; prev<=cur, out_valid<=0, state<=IDLE, k<=0. out keeps its last value.
- Throughput: R+1 cycles per input sample with no stalls, because of one IDLE bubble per sample.
- Beat R always equals cur exactly. Equal consecutive samples produce R identical outputs.
- in_valid in RUN is ignored; the source must hold its sample until in_ready=1.

Optional Feature:
- Macro: LIN_INTERP_ZOH_EN.
- Defined: zero-order-hold mode. f(k)=cur for every k; the ramp arithmetic is not instantiated; prev still updates.
- Undefined: linear interpolation as specified above.
- Handshake, latency and reset behaviour are identical in both modes.

Test Plan:
- Reset, then send in=8 with out_ready held at 1 → out sequence 2,4,6,8 on consecutive cycles; out_valid high for exactly 4 cycles; in_ready returns to 1 the cycle after the last beat.
- Following that, send in=1 → out 6,4,2,1, which checks floor behaviour on a negative slope.
- Send in=15 then in=15 → second ramp is 15,15,15,15.
- Stall: send in=12 from prev=0; hold out_ready=0 for 3 cycles after the first beat → out holds 3 with out_valid=1, then 6,9,12 once out_ready rises; in_valid asserted during RUN is ignored.
- Reset mid-ramp: assert rst=0 after beat 2 of 0→8 → out=0 and out_valid=0 immediately (asynchronously); after release, in=4 ramps 1,2,3,4 from prev=0.
- With LIN_INTERP_ZOH_EN: 0→8 → out 8,8,8,8; same handshake timing as linear mode.

Source files
------------

// File: rtl/lin_interp.sv
// lin_interp: upsampling linear interpolator for unsigned W-bit sample streams.
// Each accepted input sample produces R = 2^LOG2R output beats. The beats ramp
// linearly from the previously emitted sample to the new one, and the last beat
// equals the new sample exactly. Valid/ready flow control is used on both sides.
// Optional feature macro: LIN_INTERP_ZOH_EN. When it is defined, the block runs
// in zero-order-hold mode: every beat equals the new sample and no ramp
// arithmetic is built.
module lin_interp #(
  parameter int W     = 4,
  parameter int LOG2R = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out
);

  localparam int R = 1 << LOG2R;
  localparam logic [LOG2R:0] K_ONE  = {{LOG2R{1'b0}}, 1'b1};
  localparam logic [LOG2R:0] K_LAST = R[LOG2R:0];

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   prev, prev_nx;
  logic [W-1:0]   cur, cur_nx;
  logic [LOG2R:0] k, k_nx;
  logic [W-1:0]   out_nx;
  logic           out_valid_nx;
  logic [LOG2R:0] k_inc;

`ifdef LIN_INTERP_ZOH_EN
  // Zero-order hold: every beat repeats the new sample.
  function automatic logic [W-1:0] interp_beat(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [LOG2R:0] kk);
    return b;
  endfunction
`else
  // a + floor((b - a) * kk / R). The arithmetic shift floors toward minus
  // infinity, so the result stays in [min(a,b), max(a,b)]. Because of that,
  // truncating the sum to W bits loses nothing and no saturation is needed.
  function automatic logic [W-1:0] interp_beat(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [LOG2R:0] kk);
    logic signed [W:0]       diff;
    logic signed [W+LOG2R:0] diff_x;
    logic signed [W+LOG2R:0] k_x;
    logic signed [W+LOG2R:0] prod;
    logic signed [W+LOG2R:0] sum;
    diff   = $signed({1'b0, b}) - $signed({1'b0, a});
    diff_x = {{LOG2R{diff[W]}}, diff};
    k_x    = $signed({{W{1'b0}}, kk});
    prod   = diff_x * k_x;
    sum    = $signed({{(LOG2R+1){1'b0}}, a}) + (prod >>> LOG2R);
    return sum[W-1:0];
  endfunction
`endif

  // Input acceptance depends only on registered state.
  assign in_ready = (state == IDLE);
  assign k_inc    = k + K_ONE;

  // Next-state and next-output decode. Everything holds by default, which is
  // also what a stall (out_ready=0 in RUN) requires.
  always_comb begin
    state_nx     = state;
    prev_nx      = prev;
    cur_nx       = cur;
    k_nx         = k;
    out_nx       = out;
    out_valid_nx = out_valid;
    if (state == IDLE) begin
      if (in_valid) begin
        cur_nx       = in;
        k_nx         = K_ONE;
        state_nx     = RUN;
        out_valid_nx = 1'b1;
        out_nx       = interp_beat(prev, in, K_ONE);
      end
    end else begin
      if (out_ready) begin
        if (k == K_LAST) begin
          // The final beat carried cur, which becomes the ramp origin next time.
          prev_nx      = cur;
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
          k_nx         = '0;
        end else begin
          k_nx   = k_inc;
          out_nx = interp_beat(prev, cur, k_inc);
        end
      end
    end
  end

  // State and output registers. Asynchronous reset abandons any ramp in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      prev      <= '0;
      cur       <= '0;
      k         <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      prev      <= prev_nx;
      cur       <= cur_nx;
      k         <= k_nx;
      out       <= out_nx;
      out_valid <= out_valid_nx;
    end
  end

endmodule

// File: tb/tb_lin_interp.sv
// tb_lin_interp: directed self-checking bench for lin_interp (W=4, LOG2R=2).
// Inputs are driven on the falling edge, and outputs are sampled there too.
module tb_lin_interp;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_s;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lin_interp #(.W(4), .LOG2R(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_s)
  );

  // Present one sample for a single cycle; the caller guarantees in_ready=1.
  task automatic send_sample(input logic [3:0] v);
    in_s     = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_s !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got ready=%b valid=%b out=%0d want ready=1 valid=0 out=0",
               in_ready, out_valid, out_s);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b valid=%b want ready=1 valid=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_ramp_up();
    logic [3:0] exp [4];
`ifdef LIN_INTERP_ZOH_EN
    exp = '{4'd8, 4'd8, 4'd8, 4'd8};
`else
    exp = '{4'd2, 4'd4, 4'd6, 4'd8};
`endif
    out_ready = 1'b1;
    send_sample(4'd8);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_s !== exp[i] || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL up_beat%0d got valid=%b out=%0d ready=%b want valid=1 out=%0d ready=0",
                 i + 1, out_valid, out_s, in_ready, exp[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_s !== exp[3]) begin
      failures++;
      $display("FAIL up_done got valid=%b ready=%b out=%0d want valid=0 ready=1 out=%0d",
               out_valid, in_ready, out_s, exp[3]);
    end
  endtask

  task automatic test_ramp_down();
    logic [3:0] exp [4];
`ifdef LIN_INTERP_ZOH_EN
    exp = '{4'd1, 4'd1, 4'd1, 4'd1};
`else
    exp = '{4'd6, 4'd4, 4'd2, 4'd1};
`endif
    out_ready = 1'b1;
    send_sample(4'd1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_s !== exp[i]) begin
        failures++;
        $display("FAIL down_beat%0d got valid=%b out=%0d want valid=1 out=%0d",
                 i + 1, out_valid, out_s, exp[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL down_done got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_equal();
    logic [3:0] exp [4];
`ifdef LIN_INTERP_ZOH_EN
    exp = '{4'd15, 4'd15, 4'd15, 4'd15};
`else
    exp = '{4'd4, 4'd8, 4'd11, 4'd15};
`endif
    out_ready = 1'b1;
    send_sample(4'd15);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_s !== exp[i]) begin
        failures++;
        $display("FAIL eq_first_beat%0d got valid=%b out=%0d want valid=1 out=%0d",
                 i + 1, out_valid, out_s, exp[i]);
      end
      @(negedge clk);
    end
    send_sample(4'd15);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_s !== 4'd15) begin
        failures++;
        $display("FAIL eq_second_beat%0d got valid=%b out=%0d want valid=1 out=15",
                 i + 1, out_valid, out_s);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL eq_done got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp [4];
`ifdef LIN_INTERP_ZOH_EN
    exp = '{4'd12, 4'd12, 4'd12, 4'd12};
`else
    exp = '{4'd3, 4'd6, 4'd9, 4'd12};
`endif
    pulse_reset();
    out_ready = 1'b1;
    send_sample(4'd12);
    checks++;
    if (out_valid !== 1'b1 || out_s !== exp[0]) begin
      failures++;
      $display("FAIL stall_beat1 got valid=%b out=%0d want valid=1 out=%0d",
               out_valid, out_s, exp[0]);
    end
    // Stall the consumer and offer a competing sample that must be ignored.
    out_ready = 1'b0;
    in_s      = 4'd5;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_s !== exp[0] || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d got valid=%b out=%0d ready=%b want valid=1 out=%0d ready=0",
                 i + 1, out_valid, out_s, in_ready, exp[0]);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_s !== exp[i]) begin
        failures++;
        $display("FAIL stall_beat%0d got valid=%b out=%0d want valid=1 out=%0d",
                 i + 1, out_valid, out_s, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_done got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp [4];
    logic [3:0] exp_b2;
`ifdef LIN_INTERP_ZOH_EN
    exp    = '{4'd4, 4'd4, 4'd4, 4'd4};
    exp_b2 = 4'd8;
`else
    exp    = '{4'd1, 4'd2, 4'd3, 4'd4};
    exp_b2 = 4'd4;
`endif
    pulse_reset();
    out_ready = 1'b1;
    send_sample(4'd8);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_s !== exp_b2) begin
      failures++;
      $display("FAIL mid_beat2 got valid=%b out=%0d want valid=1 out=%0d",
               out_valid, out_s, exp_b2);
    end
    // Assert reset between edges; outputs must clear without waiting for a clock.
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_s !== 4'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_async_clear got valid=%b out=%0d ready=%b want valid=0 out=0 ready=1",
               out_valid, out_s, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_sample(4'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_s !== exp[i]) begin
        failures++;
        $display("FAIL mid_after_beat%0d got valid=%b out=%0d want valid=1 out=%0d",
                 i + 1, out_valid, out_s, exp[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_done got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_s      = 4'd0;
    out_ready = 1'b0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_equal();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
